// File: rtl/udp_test_pkg.sv
`default_nettype none
// ============================================================================
// Module   : udp_test_pkg
// Brief    : Test pattern, length limits and FSM encoding for udp_rx_checker.
// Revision : 1.0
// ============================================================================
package udp_test_pkg;

  localparam int c_PAT_LEN = 20;
  localparam int c_MAX_LEN = 1472;

  // First character of the string sits in the most significant byte.
  localparam logic [8*c_PAT_LEN-1:0] c_PATTERN = "www.meyesemi.com   \n";

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_JUDGE = 2'd2
  } rx_state_t;

  function automatic logic [7:0] pat_byte(input logic [15:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < c_PAT_LEN; k++) begin
      if (idx == 16'(k)) b = c_PATTERN[8*(c_PAT_LEN-1-k) +: 8];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/udp_rx_capture_ram.sv
`default_nettype none
// ============================================================================
// Module   : udp_rx_capture_ram
// Brief    : 32x8 capture buffer, one write port, one registered read port.
//            Present only when UDP_RX_CHK_CAPTURE_EN is defined.
// Revision : 1.0
// ============================================================================
`ifdef UDP_RX_CHK_CAPTURE_EN
module udp_rx_capture_ram (
  input  logic       rgmii_clk,
  input  logic       rstn,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] r_mem [32];

  // Storage has no reset so it maps onto distributed RAM.
  always_ff @(posedge rgmii_clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) rd_data <= 8'h00;
    else       rd_data <= r_mem[rd_addr];
  end

endmodule
`endif
`default_nettype wire

// File: rtl/udp_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : udp_rx_checker
// Brief    : Checks received UDP payloads against a fixed test pattern and
//            keeps good/bad statistics. Optional capture: UDP_RX_CHK_CAPTURE_EN.
// Revision : 1.0
// ============================================================================
module udp_rx_checker
  import udp_test_pkg::*;
#(
  parameter int EXP_LEN   = 20,
  parameter int MAX_LEN   = c_MAX_LEN,
  parameter int ALIVE_CNT = 250_000_000
) (
  input  logic        rgmii_clk,
  input  logic        rstn,
  input  logic        udp_rec_data_valid,
  input  logic [7:0]  udp_rec_rdata,
  input  logic [15:0] udp_rec_data_length,
  input  logic        clr_stats,
  output logic        pkt_done,
  output logic        pkt_ok,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt,
  output logic [15:0] err_idx,
  output logic        link_alive
`ifdef UDP_RX_CHK_CAPTURE_EN
  ,
  input  logic [4:0]  cap_addr,
  output logic [7:0]  cap_data
`endif
);

  localparam logic [15:0]         c_CNT_SAT  = 16'(MAX_LEN + 1);
  localparam logic [15:0]         c_EXP      = 16'(EXP_LEN);
  localparam int                  c_IDLE_W   = $clog2(ALIVE_CNT + 1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(ALIVE_CNT);

  rx_state_t           r_state;
  rx_state_t           w_state_nxt;
  logic [15:0]         r_cnt;
  logic [15:0]         r_len;
  logic [15:0]         r_mis_idx;
  logic [15:0]         w_idx;
  logic                r_mis;
  logic                r_ovf;
  logic                w_start;
  logic                w_byte_bad;
  logic                w_judge;
  logic                w_ok;
  logic [c_IDLE_W-1:0] r_idle;

  // A byte seen outside RECV is always index 0 of a fresh packet.
  assign w_start    = udp_rec_data_valid && (r_state != ST_RECV);
  assign w_idx      = w_start ? 16'd0 : r_cnt;
  assign w_byte_bad = (w_idx < c_EXP) && (udp_rec_rdata != pat_byte(w_idx));
  assign w_judge    = (r_state == ST_JUDGE);
  assign w_ok       = !r_mis && !r_ovf && (r_cnt == r_len) && (r_cnt >= c_EXP);

  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (udp_rec_data_valid)  w_state_nxt = ST_RECV;
      ST_RECV:  if (!udp_rec_data_valid) w_state_nxt = ST_JUDGE;
      ST_JUDGE: w_state_nxt = udp_rec_data_valid ? ST_RECV : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt     <= 16'd0;
      r_len     <= 16'd0;
      r_mis     <= 1'b0;
      r_mis_idx <= 16'd0;
      r_ovf     <= 1'b0;
    end else if (udp_rec_data_valid) begin
      if (w_start) begin
        r_cnt     <= 16'd1;
        r_len     <= udp_rec_data_length;
        r_ovf     <= (c_CNT_SAT == 16'd1);
        r_mis     <= w_byte_bad;
        r_mis_idx <= 16'd0;
      end else begin
        if (r_cnt != c_CNT_SAT) begin
          r_cnt <= r_cnt + 16'd1;
          if (r_cnt + 16'd1 == c_CNT_SAT) r_ovf <= 1'b1;
        end
        if (w_byte_bad && !r_mis) begin
          r_mis     <= 1'b1;
          r_mis_idx <= r_cnt;
        end
      end
    end
  end

  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      pkt_done <= 1'b0;
      pkt_ok   <= 1'b0;
      err_idx  <= 16'd0;
    end else begin
      pkt_done <= w_judge;
      pkt_ok   <= w_judge && w_ok;
      if (w_judge && !w_ok) err_idx <= r_mis ? r_mis_idx : r_cnt;
    end
  end

  // Clear takes priority over a verdict landing on the same edge.
  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      good_cnt <= 16'd0;
      bad_cnt  <= 16'd0;
    end else if (clr_stats) begin
      good_cnt <= 16'd0;
      bad_cnt  <= 16'd0;
    end else if (w_judge) begin
      if (w_ok) begin
        if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
      end else begin
        if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      r_idle     <= '0;
      link_alive <= 1'b0;
    end else if (udp_rec_data_valid) begin
      r_idle     <= '0;
      link_alive <= 1'b1;
    end else if (r_idle == c_IDLE_MAX) begin
      link_alive <= 1'b0;
    end else begin
      r_idle <= r_idle + 1'b1;
    end
  end

`ifdef UDP_RX_CHK_CAPTURE_EN
  logic w_cap_we;

  // Every accepted byte moves the FSM into RECV, including index 0.
  assign w_cap_we = (w_state_nxt == ST_RECV) && udp_rec_data_valid && (w_idx < 16'd32);

  udp_rx_capture_ram u_capture (
    .rgmii_clk (rgmii_clk),
    .rstn      (rstn),
    .wr_en     (w_cap_we),
    .wr_addr   (w_idx[4:0]),
    .wr_data   (udp_rec_rdata),
    .rd_addr   (cap_addr),
    .rd_data   (cap_data)
  );
`endif

endmodule
`default_nettype wire

// File: doc/udp_rx_checker.md
UDP_RX_CHECKER -- requirements
Module: udp_rx_checker

Interface
REQ-001 SHALL have parameter EXP_LEN, default 20: number of leading payload bytes compared against the test pattern.
REQ-002 SHALL have parameter MAX_LEN, default 1472: largest legal payload in bytes.
REQ-003 SHALL have parameter ALIVE_CNT, default 250_000_000: idle cycles (2 s at 125 MHz) before link_alive drops.
REQ-004 SHALL have port rgmii_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rstn, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port udp_rec_data_valid, input, 1: payload byte strobe; a contiguous high run is one packet.
REQ-007 SHALL have port udp_rec_rdata, input, 8: payload byte.
REQ-008 SHALL have port udp_rec_data_length, input, 16: declared payload byte count, stable while valid is high.
REQ-009 SHALL have port clr_stats, input, 1: synchronous clear of the counters.
REQ-010 SHALL have port pkt_done, output, 1: one-cycle end-of-packet strobe.
REQ-011 SHALL have port pkt_ok, output, 1: verdict for the packet, valid while pkt_done is high.
REQ-012 SHALL have port good_cnt, output, 16: count of good packets.
REQ-013 SHALL have port bad_cnt, output, 16: count of bad packets.
REQ-014 SHALL have port err_idx, output, 16: index of the first mismatching byte of the last bad packet.
REQ-015 SHALL have port link_alive, output, 1: high while packets keep arriving.

Function
REQ-016 Pattern SHALL be the 20 ASCII bytes "www.meyesemi.com   \n"; the byte index i is compared for i < EXP_LEN.
REQ-017 FSM SHALL have three states:
- IDLE -> RECV on valid=1, and that byte is taken as index 0.
- RECV holds while valid=1.
- RECV -> JUDGE on the first cycle with valid=0.
- JUDGE -> IDLE, or JUDGE -> RECV if valid=1; in that case the byte is index 0 of the next packet.
REQ-018 The byte counter SHALL be 16 bits, saturating at MAX_LEN+1; reaching MAX_LEN+1 SHALL set an overflow flag.
REQ-019 The packet SHALL be bad if any of these holds:
- any compared byte mismatches;
- byte count differs from udp_rec_data_length as sampled on byte 0;
- byte count < EXP_LEN;
- the overflow flag is set.
REQ-020 pkt_done and pkt_ok SHALL be registered, so pkt_done is high exactly one cycle, the cycle after JUDGE.
REQ-021 On a bad packet, err_idx SHALL be updated with pkt_done to:
- the first mismatch index, if there was a mismatch;
- otherwise the byte count.
REQ-022 good_cnt and bad_cnt SHALL increment with pkt_done and saturate at 16'hFFFF.
REQ-023 If clr_stats and pkt_done coincide, clear SHALL win and the packet SHALL NOT be counted; pkt_done and pkt_ok SHALL still pulse.
REQ-024 The idle counter SHALL reset on every valid=1; link_alive SHALL go low when the counter reaches ALIVE_CNT and high on the next valid byte.

Reset
REQ-025 rstn=0 SHALL asynchronously force:
- the FSM to IDLE;
- pkt_done, pkt_ok, good_cnt, bad_cnt, err_idx and link_alive to 0;
- all internal counters and flags to 0.
REQ-026 A reset mid-packet SHALL discard that packet; after release, the remainder of the valid run SHALL be checked as a new packet starting at index 0.

Configuration
REQ-027 With macro UDP_RX_CHK_CAPTURE_EN defined:
- a 32-byte capture buffer SHALL hold the first 32 bytes of the last packet;
- extra ports cap_addr (input, 5) and cap_data (output, 8) SHALL be present, with cap_data registered one cycle after cap_addr;
- the buffer SHALL be written only during RECV.
REQ-028 With the macro undefined, the buffer and the cap_* ports SHALL be absent, and the behaviour in REQ-016 to REQ-026 SHALL be unchanged.

Structure
REQ-029 Shared package udp_test_pkg SHALL hold the 20-byte pattern constant, its length, MAX_LEN, and the FSM state encoding.
REQ-030 The capture buffer SHALL be the sub-module udp_rx_capture_ram (32x8, one write port, one registered read port).

Verification
REQ-031 Length=20, the exact pattern over 20 cycles -> one pkt_done pulse 2 cycles after the last byte, with pkt_ok=1 and good_cnt=1.
REQ-032 Pattern with byte 5 = 8'h00 -> pkt_ok=0, bad_cnt=1, err_idx=5.
REQ-033 Declared length 20, only 19 correct bytes sent -> pkt_ok=0, err_idx=19.
REQ-034 clr_stats asserted in the pkt_done cycle of a good packet -> good_cnt=0 afterwards.
REQ-035 No valid for ALIVE_CNT cycles -> link_alive=0; next valid byte -> link_alive=1 on the following cycle.
REQ-036 rstn pulsed low at byte 10 of a 20-byte packet -> all outputs 0; the 10 trailing bytes are judged bad with err_idx=0.
